priority_queue: RTL and testbench



---
 rtl/priority_queue.sv | 162 ++++++++++++++++
 tb/tb_priority_queue.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/priority_queue.sv
// Min-priority queue held as a sorted, compacting register array.
// Supports push (with ID), pop-minimum and drop-by-ID, one operation per cycle.
module priority_queue #(
  parameter int DEPTH = 8,
  parameter int DW    = 8,
  parameter int IDW   = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           push_i,
  input  logic [DW-1:0]  data_i,
  output logic           push_rdy_o,
  output logic [IDW-1:0] push_id_o,
  input  logic           pop_i,
  output logic           pop_rdy_o,
  output logic [DW-1:0]  data_o,
  input  logic           drop_i,
  input  logic [IDW-1:0] drop_id_i,
  output logic           drop_rdy_o,
  output logic           full_o,
  output logic           empty_o,
  output logic [CW-1:0]  cnt_o,
  output logic           peek_vld_o,
  output logic [DW-1:0]  peek_data_o,
  output logic           overflow_o,
  output logic [DW-1:0]  data_overflow_o
);

  // Slot i is valid iff i < cnt_q, so the valid bits are implied by the count.
  logic [DW-1:0]  data_q [DEPTH];
  logic [DW-1:0]  data_d [DEPTH];
  logic [IDW-1:0] id_q   [DEPTH];
  logic [IDW-1:0] id_d   [DEPTH];
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] id_cnt_q, id_cnt_d;
  logic [DW-1:0]  data_o_q, data_o_d;
  logic           ovf_q, ovf_d;
  logic [DW-1:0]  ovf_data_q, ovf_data_d;

  logic           full, empty;
  logic           do_drop, do_pop, do_push;
  logic [CW-1:0]  ins_pos;
  logic [CW-1:0]  rm_pos;
  logic           rm_hit;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // Handshake: an operation fires at a rising edge when its request and its
  // ready are both high; drop beats pop beats push within one cycle.
  assign drop_rdy_o = 1'b1;
  assign pop_rdy_o  = !empty && !drop_i;
  assign push_rdy_o = !drop_i && !pop_i;

  assign do_drop = drop_i;
  assign do_pop  = pop_i && pop_rdy_o;
  assign do_push = push_i && push_rdy_o;

  always_comb begin
    ins_pos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < cnt_q && data_q[i] <= data_i) ins_pos = ins_pos + 1'b1;
    end
    rm_hit = 1'b0;
    rm_pos = '0;
    // Scan from the tail so the lowest matching slot wins.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (CW'(i) < cnt_q && id_q[i] == drop_id_i) begin
        rm_hit = 1'b1;
        rm_pos = CW'(i);
      end
    end
  end

  always_comb begin
    data_d     = data_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    id_cnt_d   = id_cnt_q;
    data_o_d   = data_o_q;
    ovf_d      = 1'b0;
    ovf_data_d = ovf_data_q;
    if (do_drop) begin
      if (rm_hit) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (CW'(i) >= rm_pos) begin
            data_d[i] = data_q[i+1];
            id_d[i]   = id_q[i+1];
          end
        end
        cnt_d = cnt_q - 1'b1;
      end
    end else if (do_pop) begin
      data_o_d = data_q[0];
      for (int i = 0; i < DEPTH - 1; i++) begin
        data_d[i] = data_q[i+1];
        id_d[i]   = id_q[i+1];
      end
      cnt_d = cnt_q - 1'b1;
    end else if (do_push) begin
      id_cnt_d = id_cnt_q + 1'b1;
      if (full && ins_pos == CW'(DEPTH)) begin
        ovf_d      = 1'b1;
        ovf_data_d = data_i;
      end else begin
        if (full) begin
          ovf_d      = 1'b1;
          ovf_data_d = data_q[DEPTH-1];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // When full the old tail simply shifts off the end.
        for (int i = 1; i < DEPTH; i++) begin
          if (CW'(i) > ins_pos) begin
            data_d[i] = data_q[i-1];
            id_d[i]   = id_q[i-1];
          end
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == ins_pos) begin
            data_d[i] = data_i;
            id_d[i]   = id_cnt_q;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        id_q[i]   <= '0;
      end
      cnt_q      <= '0;
      id_cnt_q   <= '0;
      data_o_q   <= '0;
      ovf_q      <= 1'b0;
      ovf_data_q <= '0;
    end else begin
      data_q     <= data_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      id_cnt_q   <= id_cnt_d;
      data_o_q   <= data_o_d;
      ovf_q      <= ovf_d;
      ovf_data_q <= ovf_data_d;
    end
  end

  assign push_id_o       = id_cnt_q;
  assign data_o          = data_o_q;
  assign full_o          = full;
  assign empty_o         = empty;
  assign cnt_o           = cnt_q;
  assign peek_vld_o      = !empty;
  assign peek_data_o     = empty ? '0 : data_q[0];
  assign overflow_o      = ovf_q;
  assign data_overflow_o = ovf_data_q;

endmodule

// File: tb/tb_priority_queue.sv
// Directed bench for priority_queue (DEPTH=4) with hand-computed expectations;
// popped values are checked against an expected queue.
module tb_priority_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int IDW   = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           push_i;
  logic [DW-1:0]  data_i;
  logic           push_rdy_o;
  logic [IDW-1:0] push_id_o;
  logic           pop_i;
  logic           pop_rdy_o;
  logic [DW-1:0]  data_o;
  logic           drop_i;
  logic [IDW-1:0] drop_id_i;
  logic           drop_rdy_o;
  logic           full_o;
  logic           empty_o;
  logic [CW-1:0]  cnt_o;
  logic           peek_vld_o;
  logic [DW-1:0]  peek_data_o;
  logic           overflow_o;
  logic [DW-1:0]  data_overflow_o;

  priority_queue #(.DEPTH(DEPTH), .DW(DW), .IDW(IDW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .push_i(push_i), .data_i(data_i), .push_rdy_o(push_rdy_o), .push_id_o(push_id_o),
    .pop_i(pop_i), .pop_rdy_o(pop_rdy_o), .data_o(data_o),
    .drop_i(drop_i), .drop_id_i(drop_id_i), .drop_rdy_o(drop_rdy_o),
    .full_o(full_o), .empty_o(empty_o), .cnt_o(cnt_o),
    .peek_vld_o(peek_vld_o), .peek_data_o(peek_data_o),
    .overflow_o(overflow_o), .data_overflow_o(data_overflow_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    push_i = 1'b0; pop_i = 1'b0; drop_i = 1'b0;
    data_i = '0; drop_id_i = '0;
  endtask

  // Inputs are applied 1ns after an edge; the op fires at the next edge.
  task automatic step();
    @(posedge clk_i);
    #1;
    clear_inputs();
  endtask

  task automatic push_op(input logic [DW-1:0] d);
    push_i = 1'b1; data_i = d;
    step();
  endtask

  task automatic pop_op(input logic [DW-1:0] expected, input string tag);
    logic [DW-1:0] e;
    exp_q.push_back(expected);
    pop_i = 1'b1;
    step();
    e = exp_q.pop_front();
    check(tag, 32'(data_o), 32'(e));
  endtask

  task automatic drop_op(input logic [IDW-1:0] id);
    drop_i = 1'b1; drop_id_i = id;
    step();
  endtask

  initial begin
    clear_inputs();
    rst_ni = 1'b0;
    step(); step();
    rst_ni = 1'b1;

    // reset state
    check("rst_cnt", 32'(cnt_o), 0);
    check("rst_empty", 32'(empty_o), 1);
    check("rst_full", 32'(full_o), 0);
    check("rst_peek_vld", 32'(peek_vld_o), 0);
    check("rst_peek_data", 32'(peek_data_o), 0);
    check("rst_data_o", 32'(data_o), 0);
    check("rst_ovf", 32'(overflow_o), 0);
    check("rst_ovf_data", 32'(data_overflow_o), 0);
    check("rst_push_id", 32'(push_id_o), 0);
    check("rst_push_rdy", 32'(push_rdy_o), 1);
    check("rst_pop_rdy", 32'(pop_rdy_o), 0);
    check("rst_drop_rdy", 32'(drop_rdy_o), 1);

    // sorted pops
    push_op(8'hF0); push_op(8'h15); push_op(8'h87);
    check("t1_cnt", 32'(cnt_o), 3);
    check("t1_peek", 32'(peek_data_o), 32'h15);
    check("t1_push_id", 32'(push_id_o), 3);
    pop_op(8'h15, "t1_pop0");
    pop_op(8'h87, "t1_pop1");
    pop_op(8'hF0, "t1_pop2");
    check("t1_empty", 32'(empty_o), 1);
    check("t1_peek_empty", 32'(peek_data_o), 0);

    // drop by id
    push_op(8'h01); push_op(8'hEB); push_op(8'hAF);
    pop_op(8'h01, "t2_pop0");
    drop_op(8'd4);
    check("t2_drop_cnt", 32'(cnt_o), 1);
    check("t2_drop_peek", 32'(peek_data_o), 32'hAF);
    pop_op(8'hAF, "t2_pop1");

    // interleaved push/pop
    push_op(8'h01); push_op(8'h11); push_op(8'h12);
    pop_op(8'h01, "t3_pop0");
    push_op(8'h13);
    check("t3_cnt", 32'(cnt_o), 3);
    check("t3_peek", 32'(peek_data_o), 32'h11);
    pop_op(8'h11, "t3_pop1");
    pop_op(8'h12, "t3_pop2");
    pop_op(8'h13, "t3_pop3");
    check("t3_push_id", 32'(push_id_o), 10);

    // overflow
    push_op(8'h10); push_op(8'h20); push_op(8'h30); push_op(8'h40);
    check("t4_full", 32'(full_o), 1);
    check("t4_ovf_idle", 32'(overflow_o), 0);
    push_op(8'h05);
    check("t4_ovf_evict", 32'(overflow_o), 1);
    check("t4_ovf_data_evict", 32'(data_overflow_o), 32'h40);
    check("t4_cnt_evict", 32'(cnt_o), 4);
    check("t4_peek_evict", 32'(peek_data_o), 32'h05);
    step();
    check("t4_ovf_pulse_end", 32'(overflow_o), 0);
    check("t4_ovf_data_hold", 32'(data_overflow_o), 32'h40);
    push_op(8'h50);
    check("t4_ovf_discard", 32'(overflow_o), 1);
    check("t4_ovf_data_discard", 32'(data_overflow_o), 32'h50);
    check("t4_cnt_discard", 32'(cnt_o), 4);
    check("t4_push_id", 32'(push_id_o), 16);
    pop_op(8'h05, "t4_pop0");
    pop_op(8'h10, "t4_pop1");
    pop_op(8'h20, "t4_pop2");
    pop_op(8'h30, "t4_pop3");
    check("t4_empty", 32'(empty_o), 1);

    // equal keys and ids 16, 17
    push_op(8'h22); push_op(8'h22);
    drop_op(8'd17);
    check("t5_cnt_after_drop", 32'(cnt_o), 1);
    drop_op(8'd99);
    check("t5_cnt_no_match", 32'(cnt_o), 1);
    check("t5_peek_no_match", 32'(peek_data_o), 32'h22);
    drop_op(8'd16);
    check("t5_cnt_drop_n", 32'(cnt_o), 0);

    // pop when empty
    pop_i = 1'b1;
    #1;
    check("t6_pop_rdy_empty", 32'(pop_rdy_o), 0);
    check("t6_push_rdy_pop", 32'(push_rdy_o), 0);
    step();
    check("t6_cnt_empty_pop", 32'(cnt_o), 0);
    check("t6_data_o_hold", 32'(data_o), 32'h30);

    // pop and push together: only pop fires
    push_op(8'h33);
    pop_i = 1'b1; push_i = 1'b1; data_i = 8'h44;
    #1;
    check("t6_pop_rdy", 32'(pop_rdy_o), 1);
    step();
    check("t6_both_data_o", 32'(data_o), 32'h33);
    check("t6_both_cnt", 32'(cnt_o), 0);
    check("t6_both_push_id", 32'(push_id_o), 19);

    // drop beats pop
    push_op(8'h07);
    drop_i = 1'b1; drop_id_i = 8'd200; pop_i = 1'b1;
    #1;
    check("t6_pop_rdy_drop", 32'(pop_rdy_o), 0);
    step();
    check("t6_drop_pri_cnt", 32'(cnt_o), 1);

    // reset during push
    rst_ni = 1'b0; push_i = 1'b1; data_i = 8'h02;
    step();
    rst_ni = 1'b1;
    check("t7_rst_cnt", 32'(cnt_o), 0);
    check("t7_rst_empty", 32'(empty_o), 1);
    check("t7_rst_push_id", 32'(push_id_o), 0);
    check("t7_rst_data_o", 32'(data_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
